// File: rtl/conv_core_multilane_pkg.sv
// Shared types and helpers for the multi-lane convolution core.
// RELU_EN (optional macro): clamps negative results to zero in saturate().
package conv_core_pkg;

    typedef enum logic [2:0] {IDLE, RUN, FLUSH, DRAIN, DONE} state_e;

    function automatic int clog2w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int in_depth(input int ch, input int h, input int w);
        return ch * h * w;
    endfunction

    function automatic int ker_depth(input int ch, input int k, input int oc);
        return ch * k * k * oc;
    endfunction

    function automatic int load_aw(input int a, input int b);
        return clog2w((a > b) ? a : b);
    endfunction

    // Clamp a sign-extended value into a w-bit signed range.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
`ifdef RELU_EN
        if (v < 64'sd0) return 64'sd0;
`else
        if (v < -hi - 64'sd1) return -hi - 64'sd1;
`endif
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/conv_core_multilane_if.sv
// Host load port and result stream of the convolution core.
interface conv_core_multilane_if #(
    parameter int IO_DATA_WIDTH = 16,
    parameter int LOAD_AW       = 12,
    parameter int XW            = 5,
    parameter int YW            = 5,
    parameter int CHW           = 4
);
    logic                            load_valid;
    logic                            load_ready;
    logic                            load_is_kernel;
    logic [LOAD_AW-1:0]              load_addr;
    logic [IO_DATA_WIDTH-1:0]        load_data;
    logic signed [IO_DATA_WIDTH-1:0] out_data;
    logic                            out_valid;
    logic                            out_ready;
    logic [XW-1:0]                   out_x;
    logic [YW-1:0]                   out_y;
    logic [CHW-1:0]                  out_ch;

    modport master (
        output load_valid, load_is_kernel, load_addr, load_data, out_ready,
        input  load_ready, out_data, out_valid, out_x, out_y, out_ch
    );

    modport slave (
        input  load_valid, load_is_kernel, load_addr, load_data, out_ready,
        output load_ready, out_data, out_valid, out_x, out_y, out_ch
    );
endinterface

// File: rtl/conv_core_multilane_mac_lane.sv
// One MAC lane: signed IO x IO product, wrapping accumulation, load-on-clear.
module mac_lane #(
    parameter int IO_W  = 16,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [IO_W-1:0]  a,
    input  logic [IO_W-1:0]  b,
    output logic [ACC_W-1:0] acc
);
    logic signed [2*IO_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_q, acc_d;

    always_comb begin
        prod     = (2*IO_W)'($signed(a)) * (2*IO_W)'($signed(b));
        prod_ext = ACC_W'(prod);
        acc_d    = acc_q;
        // The first step of a group loads the product instead of adding.
        if (en) acc_d = clr ? prod_ext : acc_q + prod_ext;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

    assign acc = acc_q;
endmodule

// File: rtl/conv_core_multilane.sv
// Convolution core: input/kernel buffers, loop-nest FSM, LANES MAC lanes, result stream.
// Optional macro RELU_EN (see conv_core_pkg::saturate).
module conv_core_multilane
    import conv_core_pkg::*;
#(
    parameter int IO_DATA_WIDTH = 16,
    parameter int ACC_WIDTH     = 32,
    parameter int FM_WIDTH      = 32,
    parameter int FM_HEIGHT     = 32,
    parameter int IN_CH         = 2,
    parameter int OUT_CH        = 16,
    parameter int KERNEL_SIZE   = 3,
    parameter int LANES         = 4,
    parameter int OUTPUT_SHIFT  = 0
) (
    input  logic clk,
    input  logic arst_in,
    input  logic start,
    output logic running,
    output logic done,
    conv_core_multilane_if.slave bus
);
    localparam int K         = KERNEL_SIZE;
    localparam int HK        = K / 2;
    localparam int IN_DEPTH  = in_depth(IN_CH, FM_HEIGHT, FM_WIDTH);
    localparam int KER_DEPTH = ker_depth(IN_CH, K, OUT_CH);
    localparam int NG        = OUT_CH / LANES;
    localparam int KB_DEPTH  = KER_DEPTH / LANES;
    localparam int IN_AW     = clog2w(IN_DEPTH);
    localparam int KB_AW     = clog2w(KB_DEPTH);
    localparam int XW        = clog2w(FM_WIDTH);
    localparam int YW        = clog2w(FM_HEIGHT);
    localparam int CHW       = clog2w(OUT_CH);
    localparam int GW        = clog2w(NG);
    localparam int CW        = clog2w(IN_CH);
    localparam int KW        = clog2w(K);
    localparam int LW        = clog2w(LANES);

    state_e                               state_q, state_d;
    logic [YW-1:0]                        y_q, y_d;
    logic [XW-1:0]                        x_q, x_d;
    logic [GW-1:0]                        g_q, g_d;
    logic [CW-1:0]                        c_q, c_d;
    logic [KW-1:0]                        ky_q, ky_d, kx_q, kx_d;
    logic                                 flush_q, flush_d;
    logic [LW-1:0]                        lane_q, lane_d;
    logic                                 mac_en_q, mac_en_d, mac_clr_q, mac_clr_d, pad_q, pad_d;
    logic [LANES-1:0][IO_DATA_WIDTH-1:0]  res_q, res_d, sat_val;
    logic [LANES-1:0][ACC_WIDTH-1:0]      acc;
    logic                                 out_valid_q, out_valid_d;
    logic [IO_DATA_WIDTH-1:0]             out_data_q, out_data_d;
    logic [XW-1:0]                        out_x_q, out_x_d;
    logic [YW-1:0]                        out_y_q, out_y_d;
    logic [CHW-1:0]                       out_ch_q, out_ch_d;
    logic                                 running_q, running_d, done_q, done_d;
    logic                                 load_ready_q, load_ready_d;

    // Load path
    logic                     ld_in_we, ld_ker_we;
    logic [IN_AW-1:0]         ld_iidx;
    logic [KB_AW-1:0]         ld_kidx;
    logic [LW-1:0]            ld_bank;
    int                       ld_addr;

    always_comb begin
        ld_addr   = int'(bus.load_addr);
        ld_in_we  = bus.load_valid && load_ready_q && !bus.load_is_kernel && (ld_addr < IN_DEPTH);
        ld_ker_we = bus.load_valid && load_ready_q && bus.load_is_kernel && (ld_addr < KER_DEPTH);
        ld_iidx   = IN_AW'(ld_addr);
        ld_bank   = LW'(ld_addr % LANES);
        ld_kidx   = KB_AW'(ld_addr / LANES);
    end

    // Read addressing for the current inner step; padded taps read address 0.
    int               iy, ix;
    logic             pad_rd;
    logic [IN_AW-1:0] rd_iidx;
    logic [KB_AW-1:0] rd_kidx;

    always_comb begin
        iy      = int'(y_q) + int'(ky_q) - HK;
        ix      = int'(x_q) + int'(kx_q) - HK;
        pad_rd  = (iy < 0) || (iy >= FM_HEIGHT) || (ix < 0) || (ix >= FM_WIDTH);
        rd_iidx = '0;
        if (!pad_rd) rd_iidx = IN_AW'((int'(c_q) * FM_HEIGHT + iy) * FM_WIDTH + ix);
        rd_kidx = KB_AW'(((int'(c_q) * K + int'(ky_q)) * K + int'(kx_q)) * NG + int'(g_q));
    end

    logic [IO_DATA_WIDTH-1:0] in_mem [IN_DEPTH];
    logic [IO_DATA_WIDTH-1:0] in_rd_q;
    logic [IO_DATA_WIDTH-1:0] op_a;

    always_ff @(posedge clk) begin
        if (ld_in_we) in_mem[ld_iidx] <= bus.load_data;
        in_rd_q <= in_mem[rd_iidx];
    end

    assign op_a = pad_q ? '0 : in_rd_q;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [IO_DATA_WIDTH-1:0] bank [KB_DEPTH];
        logic [IO_DATA_WIDTH-1:0] ker_rd_q;
        logic signed [63:0]       acc_sh;

        always_ff @(posedge clk) begin
            if (ld_ker_we && ld_bank == LW'(l)) bank[ld_kidx] <= bus.load_data;
            ker_rd_q <= bank[rd_kidx];
        end

        mac_lane #(.IO_W(IO_DATA_WIDTH), .ACC_W(ACC_WIDTH)) u_mac (
            .clk (clk),
            .rst (arst_in),
            .en  (mac_en_q),
            .clr (mac_clr_q),
            .a   (op_a),
            .b   (ker_rd_q),
            .acc (acc[l])
        );

        assign acc_sh     = 64'($signed(acc[l])) >>> OUTPUT_SHIFT;
        assign sat_val[l] = IO_DATA_WIDTH'(saturate(acc_sh, IO_DATA_WIDTH));
    end

    always_comb begin
        state_d     = state_q;
        y_d         = y_q;
        x_d         = x_q;
        g_d         = g_q;
        c_d         = c_q;
        ky_d        = ky_q;
        kx_d        = kx_q;
        flush_d     = flush_q;
        lane_d      = lane_q;
        res_d       = res_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_ch_d    = out_ch_q;
        mac_en_d    = 1'b0;
        mac_clr_d   = 1'b0;
        pad_d       = pad_rd;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                mac_en_d  = 1'b1;
                mac_clr_d = (c_q == '0) && (ky_q == '0) && (kx_q == '0);
                if (kx_q == KW'(K - 1)) begin
                    kx_d = '0;
                    if (ky_q == KW'(K - 1)) begin
                        ky_d = '0;
                        if (c_q == CW'(IN_CH - 1)) begin
                            c_d     = '0;
                            flush_d = 1'b0;
                            state_d = FLUSH;
                        end else c_d = c_q + 1'b1;
                    end else ky_d = ky_q + 1'b1;
                end else kx_d = kx_q + 1'b1;
            end
            // Two cycles: one for the last read, one for the last MAC update.
            FLUSH: begin
                if (!flush_q) flush_d = 1'b1;
                else begin
                    state_d     = DRAIN;
                    res_d       = sat_val;
                    lane_d      = '0;
                    out_valid_d = 1'b1;
                    out_data_d  = sat_val[0];
                    out_x_d     = x_q;
                    out_y_d     = y_q;
                    out_ch_d    = CHW'(int'(g_q) * LANES);
                end
            end
            DRAIN: begin
                if (out_valid_q && bus.out_ready) begin
                    if (lane_q == LW'(LANES - 1)) begin
                        out_valid_d = 1'b0;
                        state_d     = RUN;
                        if (g_q == GW'(NG - 1)) begin
                            g_d = '0;
                            if (x_q == XW'(FM_WIDTH - 1)) begin
                                x_d = '0;
                                if (y_q == YW'(FM_HEIGHT - 1)) begin
                                    y_d     = '0;
                                    state_d = DONE;
                                end else y_d = y_q + 1'b1;
                            end else x_d = x_q + 1'b1;
                        end else g_d = g_q + 1'b1;
                    end else begin
                        lane_d     = lane_q + 1'b1;
                        out_data_d = res_q[lane_d];
                        out_ch_d   = out_ch_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        running_d    = (state_d == RUN) || (state_d == FLUSH) || (state_d == DRAIN);
        done_d       = (state_d == DONE);
        load_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            state_q      <= IDLE;
            y_q          <= '0;
            x_q          <= '0;
            g_q          <= '0;
            c_q          <= '0;
            ky_q         <= '0;
            kx_q         <= '0;
            flush_q      <= 1'b0;
            lane_q       <= '0;
            mac_en_q     <= 1'b0;
            mac_clr_q    <= 1'b0;
            pad_q        <= 1'b0;
            res_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_ch_q     <= '0;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            y_q          <= y_d;
            x_q          <= x_d;
            g_q          <= g_d;
            c_q          <= c_d;
            ky_q         <= ky_d;
            kx_q         <= kx_d;
            flush_q      <= flush_d;
            lane_q       <= lane_d;
            mac_en_q     <= mac_en_d;
            mac_clr_q    <= mac_clr_d;
            pad_q        <= pad_d;
            res_q        <= res_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            out_ch_q     <= out_ch_d;
            running_q    <= running_d;
            done_q       <= done_d;
            load_ready_q <= load_ready_d;
        end
    end

    assign running        = running_q;
    assign done           = done_q;
    assign bus.load_ready = load_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_x      = out_x_q;
    assign bus.out_y      = out_y_q;
    assign bus.out_ch     = out_ch_q;
endmodule

// File: tb/tb_conv_core_multilane.sv
// Directed bench for conv_core_multilane on a 4x4, IN_CH=2, OUT_CH=8, LANES=4 configuration.
module tb_conv_core_multilane;
    import conv_core_pkg::*;

    localparam int FW    = 4;
    localparam int FH    = 4;
    localparam int IC    = 2;
    localparam int OC    = 8;
    localparam int K     = 3;
    localparam int L     = 4;
    localparam int IN_D  = IC * FH * FW;
    localparam int KER_D = IC * K * K * OC;
    localparam int LAW   = load_aw(IN_D, KER_D);
    localparam int NOUT  = FH * FW * OC;

    logic clk = 1'b0;
    logic arst_in, start, running, done;
    int   errors = 0;
    int   checks = 0;

    logic signed [15:0] m_in  [IN_D];
    logic signed [15:0] m_ker [KER_D];
    logic signed [15:0] got   [NOUT];

    conv_core_multilane_if #(.IO_DATA_WIDTH(16), .LOAD_AW(LAW), .XW(clog2w(FW)),
                             .YW(clog2w(FH)), .CHW(clog2w(OC))) bus ();

    conv_core_multilane #(
        .IO_DATA_WIDTH(16), .ACC_WIDTH(32), .FM_WIDTH(FW), .FM_HEIGHT(FH), .IN_CH(IC),
        .OUT_CH(OC), .KERNEL_SIZE(K), .LANES(L), .OUTPUT_SHIFT(0)
    ) dut (
        .clk(clk), .arst_in(arst_in), .start(start), .running(running), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pk(input logic v, input int x, input int y, input int ch,
                                       input logic [15:0] d);
        return {23'd0, v, 8'(x), 8'(y), 8'(ch), d};
    endfunction

    function automatic int oi(input int x, input int y, input int ch);
        return (y * FW + x) * OC + ch;
    endfunction

    // Reference: direct zero-padded convolution, 32-bit wrap, then clamp.
    function automatic logic [15:0] ref_out(input int x, input int y, input int oc);
        longint s = 0;
        int a;
        for (int c = 0; c < IC; c++)
            for (int ky = 0; ky < K; ky++)
                for (int kx = 0; kx < K; kx++) begin
                    int iy = y + ky - K / 2;
                    int ix = x + kx - K / 2;
                    if (iy >= 0 && iy < FH && ix >= 0 && ix < FW)
                        s += longint'(m_in[(c * FH + iy) * FW + ix]) *
                             longint'(m_ker[((c * K + ky) * K + kx) * OC + oc]);
                end
        a = int'(s);
`ifdef RELU_EN
        if (a < 0) a = 0;
`else
        if (a < -32768) a = -32768;
`endif
        if (a > 32767) a = 32767;
        return 16'(a);
    endfunction

    task automatic load_word(input bit is_k, input int addr, input logic [15:0] d);
        bus.load_valid     = 1'b1;
        bus.load_is_kernel = is_k;
        bus.load_addr      = LAW'(addr);
        bus.load_data      = d;
        @(negedge clk);
        bus.load_valid = 1'b0;
        if (is_k && addr < KER_D) m_ker[addr] = d;
        if (!is_k && addr < IN_D) m_in[addr] = d;
    endtask

    task automatic fill(input logic [15:0] iv, input logic [15:0] kv, input bit per_oc);
        for (int a = 0; a < IN_D; a++) load_word(1'b0, a, iv);
        for (int a = 0; a < KER_D; a++) load_word(1'b1, a, per_oc ? 16'((a % OC) + 1) : kv);
    endtask

    task automatic run(input string tag, input bit rand_rdy, input bit poke_load);
        int          idx   = 0;
        int          dones = 0;
        int          cyc   = 0;
        bit          fin   = 0;
        bit          stall = 0;
        logic [63:0] held, cur;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_running"}, running, 1);
        chk({tag, "_ldrdy_run"}, bus.load_ready, 0);
        while (!fin && cyc < 6000) begin
            if (poke_load && cyc == 3) begin
                bus.load_valid = 1'b1;
                bus.load_is_kernel = 1'b0;
                bus.load_addr = '0;
                bus.load_data = 16'h5555;
                chk({tag, "_ldrdy_poke"}, bus.load_ready, 0);
            end
            if (cyc == 4) bus.load_valid = 1'b0;
            bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            cur = pk(bus.out_valid, int'(bus.out_x), int'(bus.out_y), int'(bus.out_ch), bus.out_data);
            if (stall) chk({tag, "_hold"}, cur, held);
            stall = 0;
            if (bus.out_valid && bus.out_ready) begin
                int ey = idx / (FW * OC);
                int ex = (idx / OC) % FW;
                int ec = idx % OC;
                if (idx < NOUT) begin
                    chk({tag, "_out"}, cur, pk(1'b1, ex, ey, ec, ref_out(ex, ey, ec)));
                    got[idx] = bus.out_data;
                end
                idx++;
            end else if (bus.out_valid) begin
                stall = 1;
                held  = cur;
            end
            if (done) begin
                dones++;
                fin = 1;
                chk({tag, "_run_at_done"}, running, 0);
            end
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_finished"}, fin, 1);
        chk({tag, "_count"}, idx, NOUT);
        repeat (3) begin
            if (done) dones++;
            @(negedge clk);
        end
        chk({tag, "_done_once"}, dones, 1);
        chk({tag, "_ldrdy_end"}, bus.load_ready, 1);
    endtask

    initial begin
        arst_in = 1'b1;
        start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_is_kernel = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_running", running, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_ldrdy", bus.load_ready, 1);
        chk("rst_outs", {bus.out_data, 8'(bus.out_x), 8'(bus.out_y), 8'(bus.out_ch)}, 0);
        arst_in = 1'b0;
        @(negedge clk);

        // All ones: 8 at corners, 12 at edges, 18 in the interior (two channels).
        fill(16'd1, 16'd1, 1'b0);
        load_word(1'b1, 200, 16'd7);
        load_word(1'b0, 40, 16'd7);
        run("ones", 1'b0, 1'b1);
        chk("ones_corner00", 64'(got[oi(0, 0, 0)]), 64'(8));
        chk("ones_corner33", 64'(got[oi(3, 3, 7)]), 64'(8));
        chk("ones_edge10", 64'(got[oi(1, 0, 0)]), 64'(12));
        chk("ones_edge02", 64'(got[oi(0, 2, 5)]), 64'(12));
        chk("ones_inner11", 64'(got[oi(1, 1, 0)]), 64'(18));
        chk("ones_inner22", 64'(got[oi(2, 2, 7)]), 64'(18));

        // Kernel for oc=k is k+1, input 2: interior = 2*9*2*(k+1) = 36*(k+1).
        fill(16'd2, 16'd0, 1'b1);
        run("perch", 1'b0, 1'b0);
        for (int k = 0; k < OC; k++) chk("perch_px11", 64'(got[oi(1, 1, k)]), 64'(36 * (k + 1)));

        run("bp", 1'b1, 1'b0);

        // 0x7FFF^2 * 18 wraps to +2146304018; 8 or 12 taps wrap negative.
        fill(16'h7FFF, 16'h7FFF, 1'b0);
        run("satp", 1'b0, 1'b0);
        chk("satp_inner", 64'(got[oi(1, 1, 0)]), 64'(32767));
`ifdef RELU_EN
        chk("satp_corner", 64'(got[oi(0, 0, 0)]), 64'(0));
`else
        chk("satp_corner", 64'(got[oi(0, 0, 0)]), 64'(-32768));
`endif

        // Kernel 0x8001: interior wraps to -2146304018, corner wraps to +524280.
        fill(16'h7FFF, 16'h8001, 1'b0);
        run("satn", 1'b1, 1'b0);
`ifdef RELU_EN
        chk("satn_inner", 64'(got[oi(1, 1, 3)]), 64'(0));
`else
        chk("satn_inner", 64'(got[oi(1, 1, 3)]), 64'(-32768));
`endif
        chk("satn_corner", 64'(got[oi(3, 0, 2)]), 64'(32767));

        fill(16'd1, 16'd1, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        arst_in = 1'b1;
        #2;
        chk("mid_rst_running", running, 0);
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_ldrdy", bus.load_ready, 1);
        @(negedge clk);
        arst_in = 1'b0;
        @(negedge clk);
        run("rerun", 1'b0, 1'b0);
        chk("rerun_inner", 64'(got[oi(2, 1, 4)]), 64'(18));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/conv_core_multilane.md
Name:
conv_core_multilane

Overview:
- Next-generation convolution core: on-chip input and kernel buffers, loop-nest controller, LANES parallel MAC lanes and a streaming output port.
- Computes LANES output channels of one output pixel at a time. Uses "same" zero padding.
- All address widths come from parameters; there are no hard-coded bit slices.
- Sits between the host load/stream interface and the downstream result sink, replacing the single-MAC core.

Parameters:
IO_DATA_WIDTH, 16, operand and output word width (signed)
ACC_WIDTH, 32, accumulator width (signed)
FM_WIDTH, 32, feature-map width in pixels
FM_HEIGHT, 32, feature-map height in pixels
IN_CH, 2, input channels
OUT_CH, 16, output channels; must be a multiple of LANES
KERNEL_SIZE, 3, square kernel size, odd
LANES, 4, parallel MAC lanes (output channels per group)
OUTPUT_SHIFT, 0, arithmetic right shift applied before saturation

Ports:
clk  in  1  clock, rising edge
arst_in  in  1  asynchronous reset, active-high
load_valid  in  1  load word valid
load_ready  out  1  core accepts load words
load_is_kernel  in  1  1: kernel buffer, 0: input buffer
load_addr  in  LOAD_AW  linear word address, LOAD_AW = clog2(max(IN_DEPTH, KER_DEPTH))
load_data  in  IO_DATA_WIDTH  load word
start  in  1  start convolution (sampled in IDLE only)
running  out  1  convolution in progress
done  out  1  one-cycle pulse at completion
out_data  out  IO_DATA_WIDTH  signed result
out_valid  out  1  result valid
out_ready  in  1  sink accepts result
out_x  out  clog2(FM_WIDTH)  result column
out_y  out  clog2(FM_HEIGHT)  result row
out_ch  out  clog2(OUT_CH)  result channel

Behaviour:
- Reset: state IDLE and all counters 0. Outputs: load_ready=1, running=0, done=0, out_valid=0, out_data/out_x/out_y/out_ch=0. Buffer contents are not reset.
- Input buffer layout:
  - IN_DEPTH = IN_CH*FM_HEIGHT*FM_WIDTH.
  - Address = (c*FM_HEIGHT+y)*FM_WIDTH+x.
- Kernel buffer layout:
  - KER_DEPTH = IN_CH*K*K*OUT_CH.
  - Address = ((c*K+ky)*K+kx)*OUT_CH+oc.
  - Banked into LANES banks: bank = oc%LANES, index = address/LANES (LANES is a power of two).
- Load handshake:
  - A word is written when load_valid && load_ready.
  - load_ready = (state==IDLE).
  - An address >= depth is dropped silently.
- Start: start in IDLE moves to RUN on the next edge; running=1 from that edge. start outside IDLE is ignored.
- Loop order, outer to inner: y, x, group g (0..OUT_CH/LANES-1), then c, ky, kx.
- Inner step n:
  - Issue reads to the input buffer and all LANES kernel banks.
  - Data arrives at n+1 and goes to the MACs.
  - A pad flag is registered alongside the read.
  - iy = y+ky-K/2 and ix = x+kx-K/2 are computed at full signed width. If either is out of range, the input operand is forced to 0.
- Accumulation: the accumulator is cleared on the first step of each group, so no accumulate-with-0 mux is needed.
- Product: IO x IO signed, sign-extended to ACC_WIDTH; overflow wraps.
- Group latency: IN_CH*K*K issue cycles + 2 pipeline cycles, then DRAIN.
- DRAIN:
  - LANES results are latched and emitted lane 0 first, one per out_valid && out_ready.
  - out_ch = g*LANES+lane.
  - out_data = saturate(acc >>> OUTPUT_SHIFT) to the [-2^(W-1), 2^(W-1)-1] range.
  - out_* is held stable while out_valid && !out_ready.
- Compute does not overlap DRAIN; backpressure stalls the whole core.
- States: IDLE -> RUN -> FLUSH (2 cycles) -> DRAIN.
  - DRAIN -> RUN while groups or pixels remain.
  - DRAIN -> DONE after the last handshake.
  - DONE -> IDLE after 1 cycle, with done=1 and running=0 in that cycle.
- Reset mid-operation: immediately returns to IDLE with the reset values above. No partial output completes.

Optional Feature:
RELU_EN
- Defined: a negative shifted accumulator value produces out_data=0; positive values are saturated as normal.
- Undefined: signed saturation only.

Decomposition:
- Package conv_core_pkg holds:
  - state enum (IDLE, RUN, FLUSH, DRAIN, DONE);
  - depth/width localparam functions;
  - saturate function.
- Sub-module mac_lane: one accumulator, with clear, accumulate and operand inputs. Instantiated LANES times.

Test Plan:
- Configuration FM 4x4, IN_CH=1, OUT_CH=4, LANES=4, K=3, all input and kernel words =1:
  - outputs 4 at corners, 6 at edges, 9 at the interior;
  - 64 outputs in raster/channel order;
  - done pulses once.
- Kernel for oc=k is all (k+1), input all 2 -> at pixel (1,1), ch0..3 = 18, 36, 54, 72.
- Input 0x7FFF, kernel 0x7FFF, IN_CH=2:
  - interior out_data = 32767 (saturated);
  - with negative kernel 0x8001: -32768;
  - with RELU_EN: 0.
- Random out_ready deassertion (50%) -> identical output sequence; out_* stable during every stall.
- arst_in asserted mid-RUN:
  - next cycle running=0, out_valid=0, load_ready=1;
  - a fresh start reproduces the full correct result.
- load_valid during RUN -> load_ready=0 and the buffer is unchanged; out-of-range load_addr is ignored.
